clock_calendar_ctrl: RTL and testbench

Timekeeping and time-setting controller for the digital clock with date/calendar. Divides the system clock into a 1 s tick and advances seconds, minutes, hours, day, month and year with full calendar carry, including month lengths and leap years for 2000–2099. A button-driven state machine lets the user edit hour, minute, day, month and year. Its outputs drive the display/BCD stage directly.

---
 rtl/clock_calendar_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_clock_calendar_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_calendar_ctrl.sv
// Clock/calendar controller: 1 s prescaler, full date carry for 2000-2099,
// and a button-driven editor for hour, minute, day, month and year.
module clock_calendar_ctrl #(
    parameter int TICK_DIV  = 500,
    parameter int BLINK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year_off,
    output logic [2:0] edit_field,
    output logic       blink,
    output logic       sec_tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        RUN  = 3'd0,
        HOUR = 3'd1,
        MIN  = 3'd2,
        DAY  = 3'd3,
        MON  = 3'd4,
        YEAR = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [BW-1:0] blk_cnt, blk_cnt_nxt;
    logic          blink_nxt, tick;
    logic [5:0]    sec_nxt, min_nxt;
    logic [4:0]    hour_nxt, day_nxt, lim;
    logic [3:0]    month_nxt, m_inc;
    logic [6:0]    year_nxt, y_inc;

    // Days in month; every fourth year from 2000 is a leap year in this range
    function automatic logic [4:0] dim(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2:                    dim = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
    endfunction

    assign edit_field = state;

    // Next-state, prescaler, time/date and blink logic
    always_comb begin
        state_nxt   = state;
        pre_nxt     = pre;
        sec_nxt     = sec;
        min_nxt     = min;
        hour_nxt    = hour;
        day_nxt     = day;
        month_nxt   = month;
        year_nxt    = year_off;
        blk_cnt_nxt = blk_cnt;
        blink_nxt   = blink;
        m_inc       = (month == 4'd12) ? 4'd1 : month + 4'd1;
        y_inc       = (year_off == 7'd99) ? 7'd0 : year_off + 7'd1;
        lim         = 5'd31;
        tick        = (state == RUN) && (pre == PRE_MAX);

        case (state)
            RUN:     state_nxt = btn_mode ? HOUR : RUN;
            HOUR:    state_nxt = btn_mode ? MIN  : HOUR;
            MIN:     state_nxt = btn_mode ? DAY  : MIN;
            DAY:     state_nxt = btn_mode ? MON  : DAY;
            MON:     state_nxt = btn_mode ? YEAR : MON;
            YEAR:    state_nxt = btn_mode ? RUN  : YEAR;
            default: state_nxt = RUN;
        endcase

        if (state == RUN) begin
            if (btn_mode || tick) begin
                pre_nxt = {PW{1'b0}};
            end else begin
                pre_nxt = pre + PW'(1);
            end
        end else begin
            pre_nxt = {PW{1'b0}};
        end

        if (tick) begin
            // Whole carry chain resolves on the tick edge
            if (sec == 6'd59) begin
                sec_nxt = 6'd0;
                if (min == 6'd59) begin
                    min_nxt = 6'd0;
                    if (hour == 5'd23) begin
                        hour_nxt = 5'd0;
                        if (day == dim(month, year_off)) begin
                            day_nxt   = 5'd1;
                            month_nxt = m_inc;
                            if (month == 4'd12) begin
                                year_nxt = y_inc;
                            end else begin
                                year_nxt = year_off;
                            end
                        end else begin
                            day_nxt = day + 5'd1;
                        end
                    end else begin
                        hour_nxt = hour + 5'd1;
                    end
                end else begin
                    min_nxt = min + 6'd1;
                end
            end else begin
                sec_nxt = sec + 6'd1;
            end
        end else if (state != RUN && btn_mode) begin
            if (state == YEAR) begin
                sec_nxt = 6'd0;
            end else begin
                sec_nxt = sec;
            end
        end else if (state != RUN && btn_inc) begin
            case (state)
                HOUR: hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                MIN:  min_nxt  = (min == 6'd59) ? 6'd0 : min + 6'd1;
                DAY:  day_nxt  = (day == dim(month, year_off)) ? 5'd1 : day + 5'd1;
                MON: begin
                    month_nxt = m_inc;
                    lim       = dim(m_inc, year_off);
                    day_nxt   = (day > lim) ? lim : day;
                end
                YEAR: begin
                    year_nxt = y_inc;
                    lim      = dim(month, y_inc);
                    day_nxt  = (day > lim) ? lim : day;
                end
                default: day_nxt = day;
            endcase
        end else begin
            sec_nxt = sec;
        end

        if (state_nxt != state || state == RUN) begin
            blk_cnt_nxt = {BW{1'b0}};
            blink_nxt   = 1'b0;
        end else if (blk_cnt == BLK_MAX) begin
            blk_cnt_nxt = {BW{1'b0}};
            blink_nxt   = ~blink;
        end else begin
            blk_cnt_nxt = blk_cnt + BW'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pre      <= {PW{1'b0}};
            blk_cnt  <= {BW{1'b0}};
            blink    <= 1'b0;
            sec_tick <= 1'b0;
            sec      <= 6'd0;
            min      <= 6'd0;
            hour     <= 5'd0;
            day      <= 5'd1;
            month    <= 4'd1;
            year_off <= 7'd0;
        end else begin
            state    <= state_nxt;
            pre      <= pre_nxt;
            blk_cnt  <= blk_cnt_nxt;
            blink    <= blink_nxt;
            sec_tick <= tick;
            sec      <= sec_nxt;
            min      <= min_nxt;
            hour     <= hour_nxt;
            day      <= day_nxt;
            month    <= month_nxt;
            year_off <= year_nxt;
        end
    end

endmodule

// File: tb/tb_clock_calendar_ctrl.sv
// Scenario bench for clock_calendar_ctrl with TICK_DIV=4, BLINK_DIV=3;
// expected snapshots are queued when stimulus is issued and popped on check.
module tb_clock_calendar_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] sec, min;
    logic [4:0] hour, day;
    logic [3:0] month;
    logic [6:0] year_off;
    logic [2:0] edit_field;
    logic       blink, sec_tick;

    int n_tests = 0;
    int n_fail  = 0;
    logic [35:0] sb[$];
    logic [35:0] exp_v;

    clock_calendar_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month),
        .year_off(year_off), .edit_field(edit_field), .blink(blink),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] pack(input int s, input int mi, input int h,
                                         input int d, input int mo, input int y, input int f);
        pack = {6'(s), 6'(mi), 5'(h), 5'(d), 4'(mo), 7'(y), 3'(f)};
    endfunction

    function automatic logic [35:0] snap();
        snap = {sec, min, hour, day, month, year_off, edit_field};
    endfunction

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        edges(2);
        reset = 1'b0;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            @(negedge clk);
            btn_inc = 1'b0;
        end
    endtask

    // From reset values, set h:m d/mo/y with two editor passes, ending in RUN
    task automatic set_fields(input int h, input int m, input int d, input int mo, input int y);
        press_mode(); press_inc(h);
        press_mode(); press_inc(m);
        press_mode();
        press_mode(); press_inc(mo - 1);
        press_mode(); press_inc(y);
        press_mode();
        press_mode(); press_mode(); press_mode(); press_inc(d - 1);
        press_mode(); press_mode(); press_mode();
    endtask

    task automatic test_reset();
        do_reset();
        sb.push_back(pack(0, 0, 0, 1, 1, 0, 0));
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v || blink !== 1'b0 || sec_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got %h blink=%b tick=%b want %h blink=0 tick=0", snap(), blink, sec_tick, exp_v);
        end
    endtask

    task automatic test_free_run();
        int pulses = 0;
        do_reset();
        sb.push_back(pack(1, 0, 0, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sec_tick) pulses++;
        end
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v || pulses != 1 || sec_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tick: got %h pulses=%0d tick=%b want %h pulses=1 tick=1", snap(), pulses, sec_tick, exp_v);
        end
        sb.push_back(pack(0, 1, 0, 1, 1, 0, 0));
        for (int i = 0; i < 236; i++) begin
            @(negedge clk);
            if (sec_tick) pulses++;
        end
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v || pulses != 60) begin
            n_fail++;
            $display("FAIL one_minute: got %h pulses=%0d want %h pulses=60", snap(), pulses, exp_v);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        set_fields(23, 59, 31, 12, 99);
        sb.push_back(pack(0, 59, 23, 31, 12, 99, 0));
        sb.push_back(pack(59, 59, 23, 31, 12, 99, 0));
        sb.push_back(pack(0, 0, 0, 1, 1, 0, 0));
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL set_fields: got %h want %h", snap(), exp_v);
        end
        edges(236);
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL pre_rollover: got %h want %h", snap(), exp_v);
        end
        edges(4);
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL full_rollover: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_february();
        int yrs[2] = '{24, 23};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            set_fields(23, 59, 28, 2, yrs[k]);
            if (k == 0) sb.push_back(pack(0, 0, 0, 29, 2, 24, 0));
            else        sb.push_back(pack(0, 0, 0, 1, 3, 23, 0));
            edges(240);
            exp_v = sb.pop_front();
            n_tests++;
            if (snap() !== exp_v) begin
                n_fail++;
                $display("FAIL feb_year%0d: got %h want %h", yrs[k], snap(), exp_v);
            end
        end
    endtask

    task automatic test_day_clamp();
        do_reset();
        press_mode(); press_mode(); press_mode();
        press_inc(30);
        press_mode();
        sb.push_back(pack(0, 0, 0, 29, 2, 0, 4));
        press_inc(1);
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL clamp_month: got %h want %h", snap(), exp_v);
        end
        press_mode();
        sb.push_back(pack(0, 0, 0, 28, 2, 1, 5));
        press_inc(1);
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL clamp_year: got %h want %h", snap(), exp_v);
        end
    endtask

    task automatic test_simultaneous_and_reset();
        do_reset();
        press_mode(); press_mode();
        press_inc(10);
        sb.push_back(pack(0, 10, 0, 1, 1, 0, 3));
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL mode_beats_inc: got %h want %h", snap(), exp_v);
        end
        press_inc(4);
        sb.push_back(pack(0, 0, 0, 1, 1, 0, 0));
        #2 reset = 1'b1;
        #1;
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v || blink !== 1'b0 || sec_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_edit: got %h blink=%b want %h blink=0", snap(), blink, exp_v);
        end
        edges(1);
        reset = 1'b0;
    endtask

    task automatic test_freeze();
        logic seen = 1'b0;
        do_reset();
        edges(148);
        sb.push_back(pack(37, 0, 0, 1, 1, 0, 0));
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v) begin
            n_fail++;
            $display("FAIL run_to_37: got %h want %h", snap(), exp_v);
        end
        press_mode();
        sb.push_back(pack(37, 0, 0, 1, 1, 0, 1));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sec_tick) seen = 1'b1;
        end
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v || seen !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze: got %h tick_seen=%b want %h tick_seen=0", snap(), seen, exp_v);
        end
        n_tests++;
        if (blink !== 1'b1) begin
            n_fail++;
            $display("FAIL blink_phase: got %b want 1", blink);
        end
        press_mode();
        n_tests++;
        if (blink !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_field_change: got %b want 0", blink);
        end
        press_mode(); press_mode(); press_mode(); press_mode();
        sb.push_back(pack(0, 0, 0, 1, 1, 0, 0));
        sb.push_back(pack(0, 0, 0, 1, 1, 0, 0));
        sb.push_back(pack(1, 0, 0, 1, 1, 0, 0));
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v || blink !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_run: got %h blink=%b want %h blink=0", snap(), blink, exp_v);
        end
        edges(3);
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v || sec_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL no_early_tick: got %h tick=%b want %h tick=0", snap(), sec_tick, exp_v);
        end
        edges(1);
        exp_v = sb.pop_front();
        n_tests++;
        if (snap() !== exp_v || sec_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_after_edit: got %h tick=%b want %h tick=1", snap(), sec_tick, exp_v);
        end
        edges(1);
        n_tests++;
        if (sec_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_width: got %b want 0", sec_tick);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_rollover();
        test_february();
        test_day_clamp();
        test_simultaneous_and_reset();
        test_freeze();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
